// File: rtl/nukv_value_arbiter.sv
// Round-robin arbiter that hands one value datapath to one requester for a whole value.
// It counts words from the byte length in the first word and flags the final word.
module nukv_value_arbiter #(
   parameter int unsigned MEMORY_WIDTH = 512,
   parameter int unsigned NUM_PORTS    = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_PORTS*MEMORY_WIDTH-1:0] in_data,
   input  logic [NUM_PORTS-1:0]              in_valid,
   output logic [NUM_PORTS-1:0]              in_ready,
   output logic [MEMORY_WIDTH-1:0]           out_data,
   output logic                              out_valid,
   output logic                              out_last,
   output logic [1:0]                        out_src,
   input  logic                              out_ready,
   output logic                              busy
);

   localparam int unsigned MAX_PORTS = 4;
   localparam int unsigned BYTES_W   = MEMORY_WIDTH / 8;
   localparam int unsigned SHIFT_W   = $clog2(BYTES_W);
   localparam int unsigned LEN_W     = 16;
   localparam int unsigned CNT_W     = 11;

   typedef enum logic {IDLE, XFER} state_t;

   state_t                  state_q, state_d;
   logic [1:0]              grant_q, grant_d;
   logic [1:0]              rr_ptr_q, rr_ptr_d;
   logic                    first_q, first_d;
   logic [CNT_W-1:0]        remaining_q, remaining_d;
   logic [MEMORY_WIDTH-1:0] out_data_d;
   logic                    out_valid_d, out_last_d;
   logic [1:0]              out_src_d;

   logic [MEMORY_WIDTH-1:0] port_word [MAX_PORTS];
   logic [MAX_PORTS-1:0]    valid4;
   logic [MAX_PORTS-1:0]    ready4;
   logic [MEMORY_WIDTH-1:0] grant_word;
   logic [LEN_W-1:0]        len;
   logic [LEN_W:0]          len_round;
   logic [CNT_W-1:0]        len_words;
   logic [CNT_W-1:0]        count;
   logic                    xfer;
   logic [1:0]              pick;
   logic                    pick_valid;
   logic [1:0]              idx;

   // Pad the port view to four entries so a 2-bit index is always in range.
   for (genvar i = 0; i < MAX_PORTS; i++) begin : g_port
      if (i < NUM_PORTS) begin : g_used
         assign port_word[i] = in_data[i*MEMORY_WIDTH +: MEMORY_WIDTH];
      end else begin : g_unused
         assign port_word[i] = '0;
      end
   end

   assign valid4   = MAX_PORTS'(in_valid);
   assign in_ready = ready4[NUM_PORTS-1:0];
   assign busy     = (state_q == XFER);

   // Word count of a value from its byte length; zero length still carries one word.
   always_comb begin
      grant_word = port_word[grant_q];
      len        = grant_word[LEN_W-1:0];
      len_round  = (LEN_W+1)'(len) + (LEN_W+1)'(BYTES_W - 1);
      len_words  = (len <= LEN_W'(BYTES_W)) ? CNT_W'(1) : CNT_W'(len_round >> SHIFT_W);
   end

   // First valid requester at or after rr_ptr.
   always_comb begin
      pick       = '0;
      pick_valid = 1'b0;
      idx        = '0;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
         idx = 2'((32'(rr_ptr_q) + k) % NUM_PORTS);
         if (!pick_valid && valid4[idx]) begin
            pick       = idx;
            pick_valid = 1'b1;
         end
      end
   end

   // Next-state, grant bookkeeping and output register update.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      first_d     = first_q;
      remaining_d = remaining_q;
      out_data_d  = out_data;
      out_valid_d = out_valid;
      out_last_d  = out_last;
      out_src_d   = out_src;
      ready4      = '0;
      xfer        = 1'b0;
      count       = first_q ? len_words : remaining_q;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d = pick;
               first_d = 1'b1;
               state_d = XFER;
            end
         end
         XFER: begin
            ready4[grant_q] = !out_valid || out_ready;
            xfer            = valid4[grant_q] && ready4[grant_q];
         end
         default: state_d = IDLE;
      endcase

      if (out_valid && out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      if (xfer) begin
         out_data_d  = grant_word;
         out_src_d   = grant_q;
         out_valid_d = 1'b1;
         out_last_d  = (count == CNT_W'(1));
         first_d     = 1'b0;
         remaining_d = count;
         if (count != CNT_W'(1)) begin
            remaining_d = count - CNT_W'(1);
         end else begin
            rr_ptr_d = 2'((32'(grant_q) + 32'd1) % NUM_PORTS);
            state_d  = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         first_q     <= 1'b0;
         remaining_q <= '0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         out_src     <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         first_q     <= first_d;
         remaining_q <= remaining_d;
         out_data    <= out_data_d;
         out_valid   <= out_valid_d;
         out_last    <= out_last_d;
         out_src     <= out_src_d;
      end
   end

endmodule

// File: tb/tb_nukv_value_arbiter.sv
// Bench for nukv_value_arbiter: directed latency/reset checks plus randomized traffic
// compared against a queue-based round-robin model of whole values.
module tb_nukv_value_arbiter;

   localparam int MW  = 512;
   localparam int NP  = 4;
   localparam int BPW = MW / 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NP*MW-1:0] in_data;
   logic [NP-1:0]    in_valid;
   logic [NP-1:0]    in_ready;
   logic [MW-1:0]    out_data;
   logic             out_valid;
   logic             out_last;
   logic [1:0]       out_src;
   logic             out_ready;
   logic             busy;

   nukv_value_arbiter #(.MEMORY_WIDTH(MW), .NUM_PORTS(NP)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_last (out_last),
      .out_src  (out_src),
      .out_ready(out_ready),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [MW-1:0] data;
      logic [1:0]    src;
      logic          last;
   } exp_t;

   logic [MW-1:0] pq [NP][$];   // pending words per port
   int            vq [NP][$];   // word count of each pending value per port
   int            left [NP];    // words still owed by the value in flight
   exp_t          eq [$];       // expected output stream
   int            model_ptr;
   int            tests = 0;
   int            fails = 0;

   function automatic logic [MW-1:0] rand_word();
      logic [MW-1:0] w;
      for (int i = 0; i < MW/32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   function automatic int words_for(input int len);
      return (len == 0) ? 1 : (len + BPW - 1) / BPW;
   endfunction

   task automatic add_value(input int p, input int len);
      int n;
      logic [MW-1:0] w;
      n = words_for(len);
      for (int j = 0; j < n; j++) begin
         w = rand_word();
         if (j == 0) w[15:0] = 16'(len);
         pq[p].push_back(w);
      end
      vq[p].push_back(n);
   endtask

   // Whole values are granted in round-robin order among ports holding pending values.
   task automatic build_expected();
      int vtmp [NP][$];
      int cur [NP];
      int g, n;
      bit any;
      exp_t e;
      for (int p = 0; p < NP; p++) begin
         vtmp[p] = vq[p];
         cur[p]  = 0;
      end
      eq.delete();
      forever begin
         any = 0;
         g   = 0;
         for (int k = 0; k < NP; k++) begin
            if (!any && vtmp[(model_ptr + k) % NP].size() > 0) begin
               g   = (model_ptr + k) % NP;
               any = 1;
            end
         end
         if (!any) break;
         n = vtmp[g].pop_front();
         for (int j = 0; j < n; j++) begin
            e.data = pq[g][cur[g] + j];
            e.src  = 2'(g);
            e.last = (j == n - 1);
            eq.push_back(e);
         end
         cur[g]   += n;
         model_ptr = (g + 1) % NP;
      end
   endtask

   task automatic clear_model();
      for (int p = 0; p < NP; p++) begin
         pq[p].delete();
         vq[p].delete();
         left[p] = 0;
      end
      eq.delete();
      model_ptr = 0;
   endtask

   task automatic do_reset();
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_model();
   endtask

   task automatic run_traffic(input int ready_pct, input int stall_pct, input int budget);
      int   cyc;
      exp_t e;
      build_expected();
      cyc = 0;
      while (eq.size() != 0 && cyc < budget) begin
         @(negedge clk);
         cyc++;
         out_ready = ($urandom_range(99) < ready_pct);
         for (int p = 0; p < NP; p++) begin
            if (pq[p].size() > 0) begin
               in_valid[p]          = (left[p] > 0) ? ($urandom_range(99) >= stall_pct) : 1'b1;
               in_data[p*MW +: MW]  = pq[p][0];
            end else begin
               in_valid[p]          = 1'b0;
               in_data[p*MW +: MW]  = '0;
            end
         end
         #1;
         tests++;
         if ($countones(in_ready) > 1 || (out_valid && !out_ready && in_ready != '0)) begin
            fails++;
            $display("FAIL in_ready_rule: in_ready=%b out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
         end
         if (out_valid && out_ready) begin
            tests++;
            if (eq.size() == 0) begin
               fails++;
               $display("FAIL extra_word: src=%0d last=%b, none expected", out_src, out_last);
            end else begin
               e = eq.pop_front();
               if (out_data !== e.data || out_src !== e.src || out_last !== e.last) begin
                  fails++;
                  $display("FAIL out_word: got src=%0d last=%b data[63:0]=%h, want src=%0d last=%b data[63:0]=%h",
                           out_src, out_last, out_data[63:0], e.src, e.last, e.data[63:0]);
               end
            end
         end
         for (int p = 0; p < NP; p++) begin
            if (in_valid[p] && in_ready[p]) begin
               void'(pq[p].pop_front());
               if (left[p] == 0) left[p] = vq[p].pop_front();
               left[p]--;
            end
         end
      end
      tests++;
      if (eq.size() != 0) begin
         fails++;
         $display("FAIL traffic_timeout: %0d words outstanding after %0d cycles", eq.size(), cyc);
      end
      @(negedge clk);
      in_valid  = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      tests++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || out_src !== 2'd0 ||
          in_ready !== '0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: out_valid=%b out_last=%b out_src=%0d in_ready=%b busy=%b",
                  out_valid, out_last, out_src, in_ready, busy);
      end
   endtask

   task automatic test_single();
      logic [MW-1:0] w;
      w        = rand_word();
      w[15:0]  = 16'd40;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 4'b0001;
      in_data  = '0;
      in_data[0 +: MW] = w;
      @(negedge clk);
      #1;
      tests++;
      if (busy !== 1'b1 || in_ready !== 4'b0001) begin
         fails++;
         $display("FAIL single_grant: busy=%b in_ready=%b, want busy=1 in_ready=0001", busy, in_ready);
      end
      @(negedge clk);
      #1;
      in_valid = '0;
      tests++;
      if (out_valid !== 1'b1 || out_last !== 1'b1 || out_src !== 2'd0 || out_data !== w || busy !== 1'b0) begin
         fails++;
         $display("FAIL single_word: valid=%b last=%b src=%0d busy=%b data_ok=%b, want 1 1 0 0 1",
                  out_valid, out_last, out_src, busy, out_data === w);
      end
      @(negedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== '0) begin
         fails++;
         $display("FAIL single_drain: out_valid=%b in_ready=%b, want 0 0000", out_valid, in_ready);
      end
      model_ptr = 1;
   endtask

   task automatic test_multi();
      add_value(2, 200);
      run_traffic(100, 0, 100);
   endtask

   task automatic test_len_edges();
      add_value(1, 0);
      add_value(1, 65);
      run_traffic(100, 0, 100);
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int p = 0; p < NP; p++) add_value(p, 10 + p);
      add_value(0, 150);
      for (int p = 1; p < NP; p++) add_value(p, 64);
      run_traffic(100, 0, 200);
   endtask

   task automatic test_backpressure();
      add_value(0, 150);
      run_traffic(50, 0, 200);
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) add_value($urandom_range(NP-1), $urandom_range(700));
      run_traffic(70, 25, 3000);
   endtask

   task automatic test_reset_mid();
      logic [MW-1:0] w [5];
      int idx, cyc;
      for (int j = 0; j < 5; j++) w[j] = rand_word();
      w[0][15:0] = 16'd300;
      out_ready = 1'b1;
      idx = 0;
      cyc = 0;
      while (idx < 2 && cyc < 50) begin
         @(negedge clk);
         cyc++;
         in_valid = 4'b0010;
         in_data  = '0;
         in_data[MW +: MW] = w[idx];
         #1;
         if (in_ready[1]) idx++;
      end
      tests++;
      if (idx < 2) begin
         fails++;
         $display("FAIL reset_mid_timeout: only %0d words accepted", idx);
      end
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_data !== w[1] || busy !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid_word2: out_valid=%b busy=%b data_ok=%b, want 1 1 1", out_valid, busy, out_data === w[1]);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== '0 || out_last !== 1'b0 || out_data !== '0) begin
         fails++;
         $display("FAIL reset_mid_async: out_valid=%b busy=%b in_ready=%b, want 0 0 0000", out_valid, busy, in_ready);
      end
      in_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      clear_model();
      add_value(3, 100);
      run_traffic(100, 0, 100);
   endtask

   initial begin
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      clear_model();
      test_reset();
      test_single();
      test_multi();
      test_len_edges();
      test_round_robin();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/nukv_value_arbiter.md
# nukv_value_arbiter

Round-robin arbiter that shares one value datapath (the value segmenter input) between NUM_PORTS value-stream requesters. Each value is a burst of MEMORY_WIDTH-bit words whose first word carries the byte length in bits [15:0]. A grant is held for the whole value, and the block marks the final word. Its output drives the segmenter's value_data/value_valid/value_ready handshake directly.

## Interface
- MEMORY_WIDTH, 512, word width in bits; bytes per word = MEMORY_WIDTH/8 (64 at default).
- NUM_PORTS, 4, number of requesters, 2..4.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  NUM_PORTS*MEMORY_WIDTH  port i occupies bits [i*MEMORY_WIDTH +: MEMORY_WIDTH].
- in_valid  in  NUM_PORTS  per-port word valid.
- in_ready  out  NUM_PORTS  per-port word accept; one-hot or zero.
- out_data  out  MEMORY_WIDTH  registered word to segmenter.
- out_valid  out  1  registered valid.
- out_last  out  1  high with the final word of a value.
- out_src  out  2  index of the port that sourced out_data.
- out_ready  in  1  downstream accept.
- busy  out  1  high while a grant is held (state XFER).

## Operation
- States: IDLE, XFER.
- IDLE: if any in_valid is high, pick the first valid port scanning rr_ptr, rr_ptr+1, … (mod NUM_PORTS), latch it in grant, set first=1, go to XFER. No word is accepted in the IDLE cycle.
- XFER: in_ready[grant] = in_valid-independent (!out_valid | out_ready). All other in_ready bits stay 0. A transfer occurs when in_valid[grant] & in_ready[grant].
- First word of a value (first=1): len = in_data[grant][15:0]. words = 1 if len <= 64, else (len+63)>>6 (11-bit result; len=0 gives 1 word). Load remaining = words, then clear first.
- Each transfer loads the output register: out_data = word, out_src = grant, out_valid = 1, out_last = (word count reaches 1). The word count is the loaded value on the first word and remaining otherwise. If it is not 1, decrement remaining.
- On the last-word transfer: rr_ptr = grant+1 (mod NUM_PORTS), go to IDLE.
- Output register: clears out_valid/out_last when out_valid & out_ready and no new transfer occurs in the same cycle. A new word and a drain in the same cycle overwrite the register; the valid bit stays 1.
- Other ports' in_valid never affects an active grant. A requester that drops in_valid mid-value stalls the grant; there is no timeout.

## Timing
- Reset values: state=IDLE, grant=0, rr_ptr=0, first=0, remaining=0, out_valid=0, out_last=0, out_data=0, out_src=0, in_ready=0, busy=0.
- Arbitration latency: in_valid rises in IDLE at cycle T → busy=1 and in_ready[grant] may assert at T+1 → word visible on out_data at T+2.
- Throughput: 1 word/cycle with out_ready held high.
- Back-to-back values incur a single IDLE bubble cycle between the last word of one value and the first of the next.
- in_ready is combinational from state, grant, out_valid and out_ready. It has no combinational path from in_valid.
- rst_n low at any time, including mid-value, forces the reset values immediately. A partial value is dropped and the requester must resend from its first word.

## Test plan
- Port 0 sends len=40 (1 word), out_ready=1 → exactly one output word, out_last=1, out_src=0; busy drops the cycle after the transfer.
- Port 2 sends len=200 → 4 output words, out_last only on the 4th, out_src=2 throughout.
- len=0 on port 1, then len=65 on port 1 → first value gives 1 word with last=1; second gives 2 words with last on word 2.
- Ports 0..3 all valid with 1-word values, repeated → grant order 0,1,2,3,0; port 3's traffic never interleaves inside port 0's multi-word value.
- Port 0 sends a 3-word value with out_ready toggling 1,0,0,1,… → no word lost or duplicated; in_ready[0]=0 whenever out_valid=1 & out_ready=0.
- rst_n pulsed low after word 2 of a 5-word value → out_valid=0, busy=0 asynchronously; after release, a fresh len=100 value from port 3 completes with 2 words.
